gcd_requester: RTL and testbench

- Initiator side of the GCD core's control interface. Accepts operand pairs on a valid/ready request channel and re-arms the core with a reset pulse.
- Drives start and the shared operand bus: A in the first load cycle, B in the next. Waits for done, captures the result and returns it on a valid/ready response channel.
- Handles zero operands locally and times out a hung core.
- Sits between the system bus adapter and the GCD core.

---
 rtl/gcd_requester_if.sv | 40 ++++
 rtl/gcd_requester.sv | 206 ++++++++++++++++++++
 tb/tb_gcd_requester.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_requester_if.sv
// gcd_requester_if: bundles the request channel, the GCD core control port and the response
// channel that surround gcd_requester.
//   master : view of the requester itself (drives req_ready, core_*, rsp_valid/gcd/err)
//   slave  : view of the environment (system bus adapter, GCD core, response consumer)
// Signals:
//   req_valid/req_ready/req_a/req_b      operand request channel (valid/ready)
//   core_rst_n/core_start/core_data_in   control and operand bus towards the GCD core
//   core_done/core_result                completion and result from the GCD core
//   rsp_valid/rsp_ready/rsp_gcd/rsp_err  result response channel (valid/ready)
interface gcd_requester_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             core_rst_n;
  logic             core_start;
  logic [WIDTH-1:0] core_data_in;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;

  modport master (
    input  req_valid, req_a, req_b, core_done, core_result, rsp_ready,
    output req_ready, core_rst_n, core_start, core_data_in, rsp_valid, rsp_gcd, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, core_done, core_result, rsp_ready,
    input  req_ready, core_rst_n, core_start, core_data_in, rsp_valid, rsp_gcd, rsp_err
  );

endinterface

// File: rtl/gcd_requester.sv
// gcd_requester: initiator side of the GCD core control interface.
//
// Accepts one operand pair at a time on the request channel, re-arms the GCD core with a
// one-cycle reset pulse, loads A then B over the shared operand bus (start strobe with A),
// waits for done and returns the captured result on the response channel. A zero operand is
// answered locally without touching the core; a core that never signals done is abandoned
// after TIMEOUT_CYCLES cycles in WAIT and answered with rsp_err=1.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; aborts any in-flight request, holds core in reset
//   bus    gcd_requester_if.master (request, core control and response signals)
//   stat_ops       [15:0] response handshakes, wrapping     (GCD_REQ_STATS_EN only)
//   stat_timeouts  [15:0] timeout aborts, saturating        (GCD_REQ_STATS_EN only)
//
// Parameters:
//   WIDTH           operand/result width
//   TIMEOUT_CYCLES  cycles spent in WAIT before the request is aborted (>= 2)
//   CNT_W           timeout counter width, 2**CNT_W must exceed TIMEOUT_CYCLES
//
// Optional feature: define GCD_REQ_STATS_EN to add the stat_ops/stat_timeouts counters.
//
// All outputs are registered: each output register is loaded with the value that belongs to
// the state being entered, so outputs change in the same cycle as the state register.
module gcd_requester #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_requester_if.master  bus
`ifdef GCD_REQ_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_timeouts
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCoreRst,
    StLoadA,
    StLoadB,
    StWait,
    StResp
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_ready_q, req_ready_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             core_start_q, core_start_d;
  logic [WIDTH-1:0] core_data_q, core_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
  logic             rsp_err_q, rsp_err_d;

  logic             req_hs;
  logic             a_zero, b_zero;

  // req_ready_q is the registered copy of "state is IDLE", so it qualifies the handshake.
  assign req_hs = bus.req_valid && req_ready_q;
  assign a_zero = (bus.req_a == '0);
  assign b_zero = (bus.req_b == '0);

  // Next-state, operand latch, timeout counter and response data.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          a_d = bus.req_a;
          b_d = bus.req_b;
          if (a_zero || b_zero) begin
            // gcd(x,0) = x; gcd(0,0) is undefined and reported as an error.
            state_d   = StResp;
            rsp_gcd_d = bus.req_a | bus.req_b;
            rsp_err_d = a_zero && b_zero;
          end else begin
            state_d = StCoreRst;
          end
        end
      end

      // core_done is deliberately not looked at in these three states: it may still be
      // asserted from the previous operation.
      StCoreRst: state_d = StLoadA;
      StLoadA:   state_d = StLoadB;
      StLoadB: begin
        state_d = StWait;
        cnt_d   = '0;
      end

      StWait: begin
        if (bus.core_done) begin
          // Checked first so a done arriving on the timeout cycle still wins.
          state_d   = StResp;
          rsp_gcd_d = bus.core_result;
          rsp_err_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d   = StResp;
          rsp_gcd_d = '0;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Output register inputs, decoded from the state being entered.
  always_comb begin
    req_ready_d  = (state_d == StIdle);
    core_rst_n_d = (state_d != StCoreRst);
    core_start_d = (state_d == StLoadA);
    rsp_valid_d  = (state_d == StResp);
    core_data_d  = '0;
    if (state_d == StLoadA) begin
      core_data_d = a_q;
    end else if (state_d == StLoadB) begin
      core_data_d = b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_gcd_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      core_rst_n_q <= core_rst_n_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_gcd_q    <= rsp_gcd_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.core_rst_n   = core_rst_n_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_data_in = core_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_gcd      = rsp_gcd_q;
  assign bus.rsp_err      = rsp_err_q;

`ifdef GCD_REQ_STATS_EN
  logic [15:0] stat_ops_q, stat_timeouts_q;
  logic        rsp_hs, timeout_evt;

  assign rsp_hs      = (state_q == StResp) && bus.rsp_ready;
  assign timeout_evt = (state_q == StWait) && !bus.core_done && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q      <= '0;
      stat_timeouts_q <= '0;
    end else begin
      if (rsp_hs) begin
        stat_ops_q <= stat_ops_q + 16'd1;
      end
      if (timeout_evt && (stat_timeouts_q != 16'hFFFF)) begin
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
      end
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester with a reactive GCD core model and a behavioural
// reference (Euclid on plain integers, latency rules counted in cycles after the handshake).
module tb_gcd_requester;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;

  gcd_requester_if #(.WIDTH(W)) bus ();

`ifdef GCD_REQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_timeouts;
`endif

  gcd_requester #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef GCD_REQ_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_timeouts(stat_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int exp_ops;
  int exp_to;

  typedef struct {
    int           lat;
    logic [W-1:0] gcd;
    logic         err;
    logic         got;
    int           rst_cnt;
    int           rst_k;
    int           start_cnt;
    int           start_k;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] data_w;
    int           busy_ready;
    int           unstable;
    logic         post_valid;
    logic         post_ready;
  } obs_t;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x;
    int unsigned y;
    int unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Expected cycles from request handshake to first rsp_valid.
  function automatic int lat_ref(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                                 input bit hang);
    if (a == 0 || b == 0) return 1;
    if (hang) return 4 + TO;
    return 5 + d;
  endfunction

  // One transaction. d = WAIT cycles before the core model raises done; hang = never;
  // stale = done already high (with stale_res) before and through the load phase.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                        input bit hang, input bit stale, input logic [W-1:0] stale_res,
                        input int hold, output obs_t o);
    int k;
    int ks;
    int guard;
    o = '{default: 0};
    ks = -1;
    bus.core_done   = stale;
    bus.core_result = stale ? stale_res : '0;
    bus.rsp_ready   = 1'b0;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.core_rst_n === 1'b0) begin
        o.rst_cnt++;
        o.rst_k = k;
      end
      if (bus.core_start === 1'b1) begin
        o.start_cnt++;
        o.start_k = k;
        o.data_a  = bus.core_data_in;
        ks = k;
      end
      if (ks > 0 && k == ks + 1) o.data_b = bus.core_data_in;
      if (ks > 0 && k == ks + 2) o.data_w = bus.core_data_in;
      if (bus.req_ready === 1'b1) o.busy_ready++;
      if (bus.rsp_valid === 1'b1) break;
      // Core model: done from WAIT cycle index d onwards.
      if (ks > 0 && k >= ks + 2) begin
        if (!hang && (k - (ks + 2)) >= d) begin
          bus.core_done   = 1'b1;
          bus.core_result = gcd_ref(a, b);
        end else begin
          bus.core_done = 1'b0;
        end
      end
    end
    o.lat = k;
    o.got = (bus.rsp_valid === 1'b1);
    o.gcd = bus.rsp_gcd;
    o.err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== o.gcd || bus.rsp_err !== o.err ||
          bus.req_ready !== 1'b0)
        o.unstable++;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.core_done = 1'b0;
    o.post_valid  = bus.rsp_valid;
    o.post_ready  = bus.req_ready;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.core_done = 1'b0; bus.core_result = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.core_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_core_rst_n: got %b want 0", bus.core_rst_n); end
    n_cmp++; if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start: got %b want 0", bus.core_start); end
    n_cmp++; if (bus.core_data_in !== '0) begin n_err++; $display("FAIL rst_core_data: got %h want 0", bus.core_data_in); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_gcd !== '0) begin n_err++; $display("FAIL rst_rsp_gcd: got %h want 0", bus.rsp_gcd); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
`ifdef GCD_REQ_STATS_EN
    n_cmp++; if (stat_ops !== 16'd0 || stat_timeouts !== 16'd0) begin n_err++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_ops, stat_timeouts); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.core_rst_n !== 1'b1) begin n_err++; $display("FAIL idle_core_rst_n: got %b want 1", bus.core_rst_n); end
    exp_ops = 0;
    exp_to  = 0;
  endtask

  task automatic test_basic();
    obs_t o;
    run_op(16'd36, 16'd24, 5, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd12 || o.err !== 1'b0) begin n_err++; $display("FAIL basic_result: got %0d err %b want 12 err 0", o.gcd, o.err); end
    n_cmp++; if (o.lat != lat_ref(16'd36, 16'd24, 5, 1'b0)) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", o.lat, lat_ref(16'd36, 16'd24, 5, 1'b0)); end
    n_cmp++; if (o.rst_cnt != 1 || o.rst_k != 1) begin n_err++; $display("FAIL basic_core_rst: got cnt %0d at %0d want 1 at 1", o.rst_cnt, o.rst_k); end
    n_cmp++; if (o.start_cnt != 1 || o.start_k != 2) begin n_err++; $display("FAIL basic_start: got cnt %0d at %0d want 1 at 2", o.start_cnt, o.start_k); end
    n_cmp++; if (o.data_a !== 16'd36 || o.data_b !== 16'd24 || o.data_w !== 16'd0) begin n_err++; $display("FAIL basic_data_bus: got %0d,%0d,%0d want 36,24,0", o.data_a, o.data_b, o.data_w); end
    n_cmp++; if (o.busy_ready != 0) begin n_err++; $display("FAIL basic_busy_ready: got %0d cycles want 0", o.busy_ready); end
    n_cmp++; if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin n_err++; $display("FAIL basic_return_idle: got valid %b ready %b want 0 1", o.post_valid, o.post_ready); end
  endtask

  task automatic test_bypass();
    obs_t o;
    run_op(16'd7, 16'd0, 0, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd7 || o.err !== 1'b0 || o.lat != 1) begin n_err++; $display("FAIL bypass_7_0: got %0d err %b lat %0d want 7 err 0 lat 1", o.gcd, o.err, o.lat); end
    n_cmp++; if (o.rst_cnt != 0 || o.start_cnt != 0) begin n_err++; $display("FAIL bypass_no_core: got rst %0d start %0d want 0 0", o.rst_cnt, o.start_cnt); end
    run_op(16'd0, 16'd0, 0, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd0 || o.err !== 1'b1 || o.lat != 1) begin n_err++; $display("FAIL bypass_0_0: got %0d err %b lat %0d want 0 err 1 lat 1", o.gcd, o.err, o.lat); end
    run_op(16'd0, 16'h1234, 0, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'h1234 || o.err !== 1'b0) begin n_err++; $display("FAIL bypass_0_b: got %h err %b want 1234 err 0", o.gcd, o.err); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(16'd9, 16'd6, 0, 1'b1, 1'b0, '0, 0, o);
    exp_ops++;
    exp_to++;
    n_cmp++; if (o.gcd !== 16'd0 || o.err !== 1'b1) begin n_err++; $display("FAIL timeout_result: got %0d err %b want 0 err 1", o.gcd, o.err); end
    n_cmp++; if (o.lat != lat_ref(16'd9, 16'd6, 0, 1'b1)) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, lat_ref(16'd9, 16'd6, 0, 1'b1)); end
`ifdef GCD_REQ_STATS_EN
    n_cmp++; if (stat_timeouts !== 16'(exp_to)) begin n_err++; $display("FAIL timeout_stat: got %0d want %0d", stat_timeouts, exp_to); end
`endif
    // done on the last WAIT cycle collides with the timeout; done must win.
    run_op(16'd9, 16'd6, TO - 1, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd3 || o.err !== 1'b0 || o.lat != 4 + TO) begin n_err++; $display("FAIL timeout_tie: got %0d err %b lat %0d want 3 err 0 lat %0d", o.gcd, o.err, o.lat, 4 + TO); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_op(16'd15, 16'd10, 2, 1'b0, 1'b0, '0, 10, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd5 || o.err !== 1'b0) begin n_err++; $display("FAIL bp_result: got %0d err %b want 5 err 0", o.gcd, o.err); end
    n_cmp++; if (o.unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles want 0", o.unstable); end
    n_cmp++; if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got valid %b ready %b want 0 1", o.post_valid, o.post_ready); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   seen;
    bus.req_a = 16'd100; bus.req_b = 16'd75; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);  // now in WAIT
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0 || bus.core_rst_n !== 1'b0 || bus.core_start !== 1'b0 ||
                 bus.core_data_in !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_gcd !== '0 ||
                 bus.rsp_err !== 1'b0)
      begin n_err++; $display("FAIL midrst_outputs: got rdy %b crst %b st %b d %h v %b g %h e %b want all 0", bus.req_ready, bus.core_rst_n, bus.core_start, bus.core_data_in, bus.rsp_valid, bus.rsp_gcd, bus.rsp_err); end
`ifdef GCD_REQ_STATS_EN
    n_cmp++; if (stat_ops !== 16'd0 || stat_timeouts !== 16'd0) begin n_err++; $display("FAIL midrst_stats: got %0d/%0d want 0/0", stat_ops, stat_timeouts); end
`endif
    exp_ops = 0;
    exp_to  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen); end
    run_op(16'd8, 16'd12, 3, 1'b0, 1'b0, '0, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd4 || o.err !== 1'b0) begin n_err++; $display("FAIL midrst_next: got %0d err %b want 4 err 0", o.gcd, o.err); end
  endtask

  task automatic test_stale_done();
    obs_t o;
    run_op(16'd21, 16'd14, 3, 1'b0, 1'b1, 16'hDEAD, 0, o);
    exp_ops++;
    n_cmp++; if (o.gcd !== 16'd7 || o.err !== 1'b0) begin n_err++; $display("FAIL stale_result: got %h err %b want 7 err 0", o.gcd, o.err); end
    n_cmp++; if (o.lat != lat_ref(16'd21, 16'd14, 3, 1'b0)) begin n_err++; $display("FAIL stale_latency: got %0d want %0d", o.lat, lat_ref(16'd21, 16'd14, 3, 1'b0)); end
  endtask

  task automatic test_random();
    obs_t         o;
    logic [W-1:0] a, b, eg;
    logic         ee;
    int           d, hold, el;
    bit           hang, stale;
    for (int n = 0; n < 24; n++) begin
      a     = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 600));
      b     = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 600));
      hang  = ($urandom_range(0, 4) == 0);
      stale = ($urandom_range(0, 1) == 1);
      d     = $urandom_range(0, TO - 1);
      hold  = $urandom_range(0, 3);
      el    = lat_ref(a, b, d, hang);
      if (a == 0 || b == 0) begin
        eg = gcd_ref(a, b);
        ee = (a == 0 && b == 0);
      end else if (hang) begin
        eg = '0;
        ee = 1'b1;
        exp_to++;
      end else begin
        eg = gcd_ref(a, b);
        ee = 1'b0;
      end
      run_op(a, b, d, hang, stale, W'($urandom), hold, o);
      exp_ops++;
      n_cmp++; if (o.gcd !== eg || o.err !== ee || o.lat != el || o.unstable != 0) begin n_err++; $display("FAIL rand_%0d a=%0d b=%0d: got %0d err %b lat %0d unst %0d want %0d err %b lat %0d unst 0", n, a, b, o.gcd, o.err, o.lat, o.unstable, eg, ee, el); end
    end
  endtask

  task automatic test_stats();
`ifdef GCD_REQ_STATS_EN
    n_cmp++; if (stat_ops !== 16'(exp_ops) || stat_timeouts !== 16'(exp_to)) begin n_err++; $display("FAIL stats_final: got %0d/%0d want %0d/%0d", stat_ops, stat_timeouts, exp_ops, exp_to); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_stale_done();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
